// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - WS2812 line timing shared by the LED transmitter and receiver
package ws2812_pkg;

  localparam int T_ON         = 10;
  localparam int T_OFF        = 5;
  localparam int T_PERIOD     = T_ON + T_OFF;
  localparam int T_RESET      = 600;
  localparam int BITS_PER_LED = 24;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// rtl/ws2812_rx_sync.sv - two-flop synchronizer and edge detect for the WS2812 data line
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_din_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_din_s;
  logic r_din_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_din_s <= 1'b0;
      r_din_d <= 1'b0;
    end else begin
      r_meta  <= i_din;
      r_din_s <= r_meta;
      r_din_d <= r_din_s;
    end
  end

  assign o_din_s = r_din_s;
  assign o_rise  = r_din_s & ~r_din_d;
  assign o_fall  = ~r_din_s & r_din_d;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 NRZ decoder: pulse-width bit slicing, 24-bit words, reset-gap framing
module ws2812_rx #(
  parameter int CLK_HZ   = 12_000_000,
  parameter int T_ON     = ws2812_pkg::T_ON,
  parameter int T_OFF    = ws2812_pkg::T_OFF,
  parameter int T_THRESH = (T_ON + T_OFF) / 2,
  parameter int MIN_HIGH = 2,
  parameter int MAX_HIGH = ws2812_pkg::T_PERIOD - 1,
  parameter int T_RESET  = ws2812_pkg::T_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic        error
);

  import ws2812_pkg::*;

  if (CLK_HZ <= 0 || T_RESET < 2 || T_RESET > 1023) begin : g_param_check
    $error("ws2812_rx: CLK_HZ must be positive and T_RESET must fit the 10-bit gap counter");
  end

  localparam logic [3:0] HC_MIN    = 4'(MIN_HIGH);
  localparam logic [3:0] HC_MAX    = 4'(MAX_HIGH);
  localparam logic [3:0] HC_THRESH = 4'(T_THRESH);
  localparam logic [9:0] LC_LAST   = 10'(T_RESET - 1);
  localparam logic [4:0] BC_WORD   = 5'(BITS_PER_LED);

  logic w_din_s;
  logic w_rise;
  logic w_fall;

  ws2812_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_din   (din),
    .o_din_s (w_din_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  rx_state_t   r_state;
  logic [3:0]  r_high_cnt;
  logic [9:0]  r_low_cnt;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_word_idx;
  logic [23:0] r_shift;
  logic [23:0] r_rgb_data;
  logic [7:0]  r_led_num;
  logic        r_valid;
  logic        r_frame_done;
  logic        r_error;

  logic [3:0]  w_high_inc;
  logic        w_high_err;
  logic [23:0] w_shift_next;
  logic [4:0]  w_bit_cnt_next;
  logic [7:0]  w_word_idx_inc;

  assign w_high_inc     = (r_high_cnt > HC_MAX) ? r_high_cnt : r_high_cnt + 4'd1;
  // Over-long pulses are flagged on the cycle the count would pass MAX_HIGH, not after the fall.
  assign w_high_err     = w_fall ? (r_high_cnt < HC_MIN) : (w_high_inc > HC_MAX);
  assign w_shift_next   = {r_shift[22:0], (r_high_cnt > HC_THRESH)};
  assign w_bit_cnt_next = r_bit_cnt + 5'd1;
  assign w_word_idx_inc = (r_word_idx == 8'hFF) ? 8'hFF : r_word_idx + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SYNC;
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_word_idx   <= '0;
      r_shift      <= '0;
      r_rgb_data   <= '0;
      r_led_num    <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
      case (r_state)
        SYNC: begin
          if (w_din_s) begin
            r_low_cnt <= '0;
          end else if (r_low_cnt == LC_LAST) begin
            r_low_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_low_cnt <= r_low_cnt + 10'd1;
          end
        end
        IDLE: begin
          if (w_rise) begin
            r_high_cnt <= 4'd1;
            r_state    <= HIGH;
          end
        end
        HIGH: begin
          if (w_high_err) begin
            r_error    <= 1'b1;
            r_bit_cnt  <= '0;
            r_word_idx <= '0;
            r_low_cnt  <= '0;
            r_state    <= SYNC;
          end else if (w_fall) begin
            r_shift   <= w_shift_next;
            r_low_cnt <= 10'd1;
            r_state   <= LOW;
            if (w_bit_cnt_next == BC_WORD) begin
              r_rgb_data <= w_shift_next;
              r_led_num  <= r_word_idx;
              r_valid    <= 1'b1;
              r_bit_cnt  <= '0;
              r_word_idx <= w_word_idx_inc;
            end else begin
              r_bit_cnt <= w_bit_cnt_next;
            end
          end else begin
            r_high_cnt <= w_high_inc;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_high_cnt <= 4'd1;
            r_state    <= HIGH;
          end else if (r_low_cnt == LC_LAST) begin
            r_frame_done <= 1'b1;
            r_error      <= (r_bit_cnt != 5'd0);
            r_bit_cnt    <= '0;
            r_word_idx   <= '0;
            r_low_cnt    <= '0;
            r_state      <= IDLE;
          end else begin
            r_low_cnt <= r_low_cnt + 10'd1;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign rgb_data   = r_rgb_data;
  assign led_num    = r_led_num;
  assign valid      = r_valid;
  assign frame_done = r_frame_done;
  assign error      = r_error;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - scoreboard bench for ws2812_rx driven from a pulse-level line model
module tb_ws2812_rx;

  localparam int MIN_H   = 2;
  localparam int MAX_H   = 14;
  localparam int THRESH  = 7;
  localparam int GAP     = 600;
  localparam int SYNC_LAT = 2;
  localparam int GAP_LEN = 650;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        valid;
  logic        frame_done;
  logic        error;

  ws2812_rx dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .valid      (valid),
    .frame_done (frame_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          v;
    bit          fd;
    bit          er;
    logic [23:0] data;
    logic [7:0]  led;
    int          at;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  bit          m_synced;
  bit          m_any;
  int          m_nb;
  int          m_idx;
  logic [23:0] m_word;
  int          m_last_fall;

  function automatic void push(bit v, bit fd, bit er, logic [23:0] d, logic [7:0] l, int at);
    ev_t e;
    e.v = v; e.fd = fd; e.er = er; e.data = d; e.led = l; e.at = at;
    exp_q.push_back(e);
  endfunction

  function automatic void desync();
    m_synced = 1'b0;
    m_any    = 1'b0;
    m_nb     = 0;
    m_idx    = 0;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (valid || frame_done || error)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event cyc=%0d got v/fd/er=%b%b%b rgb=%h led=%0d, none required",
                 cyc, valid, frame_done, error, rgb_data, led_num);
      end else begin
        e = exp_q.pop_front();
        if ({valid, frame_done, error} != {e.v, e.fd, e.er} || cyc != e.at ||
            (e.v && (rgb_data != e.data || led_num != e.led))) begin
          n_err++;
          $display("FAIL event cyc=%0d got v/fd/er=%b%b%b rgb=%h led=%0d, required v/fd/er=%b%b%b rgb=%h led=%0d at cyc=%0d",
                   cyc, valid, frame_done, error, rgb_data, led_num, e.v, e.fd, e.er, e.data, e.led, e.at);
        end
      end
    end
  end

  task automatic wait_edges(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One high pulse of h cycles followed by l low cycles, both measured at the pin.
  task automatic send_bit(int h, int l);
    int r = cyc;
    if (m_synced) begin
      if (h > MAX_H) begin
        push(1'b0, 1'b0, 1'b1, '0, '0, r + SYNC_LAT + MAX_H + 1);
        desync();
      end else if (h < MIN_H) begin
        push(1'b0, 1'b0, 1'b1, '0, '0, r + h + SYNC_LAT + 1);
        desync();
      end else begin
        m_word = {m_word[22:0], (h > THRESH)};
        m_nb++;
        m_any = 1'b1;
        if (m_nb == 24) begin
          push(1'b1, 1'b0, 1'b0, m_word, (m_idx > 255) ? 8'hFF : 8'(m_idx), r + h + SYNC_LAT + 1);
          m_idx++;
          m_nb = 0;
        end
      end
    end
    m_last_fall = r + h;
    din = 1'b1;
    wait_edges(h);
    din = 1'b0;
    wait_edges(l);
  endtask

  task automatic send_bit_val(bit b, int mode);
    int h;
    int l;
    case (mode)
      0: begin h = b ? 10 : 5; l = 15 - h; end
      1: begin h = b ? 8 : 7; l = 6; end
      2: begin h = b ? int'($urandom_range(8, 14)) : int'($urandom_range(2, 7)); l = int'($urandom_range(1, 30)); end
      default: begin h = b ? 8 : 2; l = 1; end
    endcase
    send_bit(h, l);
  endtask

  task automatic send_word(logic [23:0] w, int mode);
    for (int i = 23; i >= 0; i--) send_bit_val(w[i], mode);
  endtask

  task automatic gap(int n);
    if (m_synced && m_any) begin
      push(1'b0, 1'b1, (m_nb != 0), '0, '0, m_last_fall + SYNC_LAT + GAP);
      m_any = 1'b0;
      m_nb  = 0;
      m_idx = 0;
    end else if (!m_synced && n >= GAP) begin
      m_synced = 1'b1;
    end
    din = 1'b0;
    wait_edges(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_edges(3);
    n_vec++;
    if ({rgb_data, led_num, valid, frame_done, error} != 35'd0) begin
      n_err++;
      $display("FAIL reset_state got rgb=%h led=%0d v/fd/er=%b%b%b, required all zero",
               rgb_data, led_num, valid, frame_done, error);
    end
    reset = 1'b0;
    desync();
    m_word = '0;
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    do_reset();
    gap(GAP_LEN);

    send_word(24'hA5C3F0, 0);
    gap(GAP_LEN);

    send_word(24'h00FF00, 0);
    send_word(24'h123456, 0);
    send_word(24'hFFFFFF, 0);
    gap(GAP_LEN);
    send_word(24'h0F0F0F, 0);
    gap(GAP_LEN);

    for (int i = 0; i < 12; i++) send_bit_val(i[0], 0);
    gap(GAP_LEN);
    send_word(24'h5A5A5A, 0);
    gap(GAP_LEN);

    for (int i = 0; i < 5; i++) send_bit_val(~i[0], 0);
    send_bit(1, 10);
    for (int i = 0; i < 3; i++) send_bit_val(1'b1, 0);
    gap(GAP_LEN);
    send_word(24'hC0FFEE, 0);
    gap(GAP_LEN);

    send_word(24'hA5A5A5, 1);
    gap(GAP_LEN);
    for (int i = 0; i < 24; i++) send_bit((i % 2 == 0) ? MAX_H : MIN_H, 3);
    gap(GAP_LEN);
    send_bit(15, 10);
    gap(GAP_LEN);
    send_word(24'h3C3C3C, 0);
    gap(GAP_LEN);

    for (int i = 0; i < 10; i++) send_bit_val(i[1], 0);
    wait_edges(5);
    do_reset();
    send_word(24'h777777, 0);
    gap(GAP_LEN);
    send_word(24'h1E1E1E, 0);
    gap(GAP_LEN);

    for (int f = 0; f < 6; f++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) send_word(24'($urandom), 2);
      gap(GAP_LEN);
    end

    for (int k = 0; k < 257; k++) send_word(24'($urandom), 3);
    gap(GAP_LEN);

    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) wait_edges(1);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d outstanding events, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
